// File: rtl/count_disp_pkg.sv
// count_disp_pkg: shared types and constants for the BCD display converter.
//   state_e    - converter FSM states
//   SEG_BLANK  - active-low pattern with every segment off
//   SEG_LUT    - active-low gfedcba codes for decimal digits 0..9
//   pow10()    - constant helper used for the digit-capacity check
`timescale 1ns/1ps
package count_disp_pkg;

    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

endpackage

// File: rtl/count_bcd_display_if.sv
// count_bcd_display_if: groups the counter input and the display-side outputs.
//   count_in  binary count from the upstream counter
//   bcd_out   registered BCD, digit d at [4d+:4]
//   seg_out   registered active-low segments, digit d at [7d+:7]
//   busy/done/valid  conversion status
// Modports: master = counter/monitor side, slave = converter.
`timescale 1ns/1ps
interface count_bcd_display_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic [WIDTH-1:0]    count_in;
    logic [4*DIGITS-1:0] bcd_out;
    logic [7*DIGITS-1:0] seg_out;
    logic                busy;
    logic                done;
    logic                valid;

    modport master (output count_in, input bcd_out, seg_out, busy, done, valid);
    modport slave  (input count_in, output bcd_out, seg_out, busy, done, valid);
endinterface

// File: rtl/count_bcd_display_seg7_encode.sv
// seg7_encode: combinational BCD nibble to active-low 7-segment code.
//   nibble_i  BCD digit (values above 9 show as blank)
//   seg_o     gfedcba at [6:0], active-low
`timescale 1ns/1ps
module seg7_encode
    import count_disp_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);
    always_comb begin
        seg_o = SEG_BLANK;
        if (nibble_i <= 4'd9) seg_o = SEG_LUT[nibble_i];
    end
endmodule

// File: rtl/count_bcd_display.sv
// count_bcd_display: samples a binary count and converts it to decimal for
// 7-segment displays using sequential double-dabble (one bit per clock).
//   clk  rising-edge clock
//   r    asynchronous active-high reset
//   bus  slave modport: count_in in; bcd_out, seg_out, busy, done, valid out
// Results land in output registers only at the end of a conversion, so the
// displays never show partial values.
`timescale 1ns/1ps
module count_bcd_display
    import count_disp_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                clk,
    input  logic                r,
    count_bcd_display_if.slave  bus
);
    localparam int BW     = 4 * DIGITS;
    localparam int SW     = 7 * DIGITS;
    localparam int ITER_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
        $error("count_bcd_display: WIDTH must be 1..16");
    end
    if (pow10(DIGITS) <= (64'd1 << WIDTH) - 64'd1) begin : g_bad_digits
        $error("count_bcd_display: DIGITS too small for WIDTH");
    end

    state_e            state_q,   state_d;
    logic [WIDTH-1:0]  bin_q,     bin_d;
    logic [WIDTH-1:0]  last_q,    last_d;
    logic [BW-1:0]     work_q,    work_d;
    logic [BW-1:0]     bcd_q,     bcd_d;
    logic [SW-1:0]     seg_q,     seg_d;
    logic [ITER_W-1:0] iter_q,    iter_d;
    logic              pending_q, pending_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;
    logic              valid_q,   valid_d;

    logic [BW-1:0]     work_adj;
    logic [SW-1:0]     seg_raw;
    logic [SW-1:0]     seg_enc;

    // Double-dabble correction: each nibble >= 5 gets +3 so the following
    // shift carries into the next decimal digit.
    always_comb begin
        work_adj = work_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (work_q[4*d +: 4] >= 4'd5) work_adj[4*d +: 4] = work_q[4*d +: 4] + 4'd3;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_enc
        seg7_encode u_enc (
            .nibble_i (work_q[4*g +: 4]),
            .seg_o    (seg_raw[7*g +: 7])
        );
    end

    // Leading-zero blanking, scanning from the top digit down; the units
    // digit is never blanked and interior zeros stay visible.
    always_comb begin
        logic hi_zero;
        seg_enc = seg_raw;
        hi_zero = 1'b1;
        // NOTE: hi_zero is a combinational temporary updated in loop order,
        // so it needs blocking assignments to carry the running result.
        for (int d = DIGITS - 1; d >= 1; d--) begin
            hi_zero = hi_zero && (work_q[4*d +: 4] == 4'd0);
            if (BLANK_LZ && hi_zero) seg_enc[7*d +: 7] = SEG_BLANK;
        end
    end

    always_comb begin
        // NOTE: every next-state value defaults to its current value first so
        // no path through the case leaves a signal unassigned (no latches).
        state_d   = state_q;
        bin_d     = bin_q;
        last_d    = last_q;
        work_d    = work_q;
        bcd_d     = bcd_q;
        seg_d     = seg_q;
        iter_d    = iter_q;
        pending_d = pending_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        valid_d   = valid_q;

        unique case (state_q)
            IDLE: begin
                if ((bus.count_in != last_q) || pending_q) begin
                    bin_d     = bus.count_in;
                    last_d    = bus.count_in;
                    work_d    = '0;
                    iter_d    = '0;
                    pending_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = CONV;
                end
            end
            CONV: begin
                {work_d, bin_d} = {work_adj, bin_q} << 1;
                iter_d = iter_q + 1'b1;
                if (iter_q == ITER_W'(WIDTH - 1)) state_d = LOAD;
            end
            LOAD: begin
                bcd_d   = work_q;
                seg_d   = seg_enc;
                done_d  = 1'b1;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // pending forces a conversion of whatever count is held after reset.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            last_q    <= '0;
            work_q    <= '0;
            bcd_q     <= '0;
            iter_q    <= '0;
            pending_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            for (int d = 0; d < DIGITS; d++) begin
                seg_q[7*d +: 7] <= ((d == 0) || !BLANK_LZ) ? SEG_LUT[0] : SEG_BLANK;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state_q   <= state_d;
            bin_q     <= bin_d;
            last_q    <= last_d;
            work_q    <= work_d;
            bcd_q     <= bcd_d;
            seg_q     <= seg_d;
            iter_q    <= iter_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.bcd_out = bcd_q;
    assign bus.seg_out = seg_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.valid   = valid_q;

endmodule

// File: doc/count_bcd_display.md
Name: count_bcd_display

Overview:
- Downstream consumer of the parameterised binary counter (`pCounter`): samples its `out` bus and converts it to decimal for the board's 7-segment displays.
- Conversion is sequential double-dabble, one bit per clock, with a start/busy/done flow.
- Results are held in output registers, so the displays never show partial values.
- Leading zeros can optionally be blanked.

Parameters:
- WIDTH, 8, width of count_in; legal 1..16.
- DIGITS, 3, number of decimal digits; elaboration $error if 10**DIGITS <= 2**WIDTH-1.
- BLANK_LZ, 1, 1 = blank leading zero digits; units digit is never blanked.

Ports:
- clk  input  1  system clock, rising edge.
- r  input  1  reset, asynchronous, active-high.
- count_in  input  WIDTH  binary count from pCounter out.
- bcd_out  output  4*DIGITS  registered BCD; digit d at [4d+:4], d=0 is units.
- seg_out  output  7*DIGITS  registered segments, active-low; digit d at [7d+:7]; bit order g,f,e,d,c,b,a at [6:0].
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse when bcd_out/seg_out update.
- valid  output  1  at least one conversion completed since reset.

Behaviour:
- Reset (async, while r=1):
  - state=IDLE; bcd_out=0; busy=0; done=0; valid=0; pending=1.
  - Internal last=0, shift regs=0, iteration counter=0.
  - seg_out: units=7'b1000000; other digits=7'h7F if BLANK_LZ, else 7'b1000000.
- FSM states: IDLE, CONV, LOAD.
- IDLE, at a rising edge with (count_in != last) or pending:
  - bin<=count_in; last<=count_in; bcd work<=0; iter<=0; pending<=0; busy<=1; state<=CONV.
  - Call this edge E.
- CONV, each edge:
  - Every work nibble >=5 gets +3 (4-bit, no carry between nibbles).
  - Then {work,bin} shifts left by 1; iter++.
  - After the WIDTH-th step (iter==WIDTH-1 at that edge), state<=LOAD.
  - CONV occupies edges E+1..E+WIDTH.
- LOAD, edge E+WIDTH+1:
  - bcd_out<=work; seg_out<=encode(work); done<=1 for this cycle only.
  - valid<=1 (sticky until reset); busy<=0; state<=IDLE.
- Latency: WIDTH+1 clocks from capture edge to outputs valid. Minimum IDLE dwell is 1 cycle, so back-to-back conversions take WIDTH+2 cycles each.
- count_in changes while busy are ignored. On return to IDLE the next edge compares against last and re-captures if it differs, so the final stable value is always displayed.
- Leading-zero blanking (BLANK_LZ=1): digit d>0 is driven to 7'h7F when it and all higher digits are zero. Interior zeros are shown.
- Segment codes 0-9 (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibbles >9 are unreachable; map them to 7'h7F.
- Reset mid-conversion: immediate return to reset values. pending=1, so the held count_in is reconverted on the first edge after r falls.
- No combinational path from count_in to any output.

Decomposition:
- Package count_disp_pkg:
  - state enum typedef {IDLE, CONV, LOAD}.
  - SEG_BLANK=7'h7F.
  - SEG_LUT constant array [0:9] of 7-bit codes.
- Sub-module seg7_encode (combinational, nibble -> 7 bits, uses SEG_LUT). Instantiated DIGITS times via generate.
- Blanking logic and FSM stay in the top.

Test Plan (WIDTH=8, DIGITS=3, BLANK_LZ=1, 4 ns clock as in the counter bench):
- r=1 for 1 ns mid-cycle -> immediately bcd_out=12'h000, seg_out={7F,7F,1000000}, busy=0, valid=0, done=0.
- Release r with count_in=0 -> busy=1 after first edge; done pulses exactly 9 edges later; bcd_out=12'h000; valid=1.
- count_in=255 held -> after 9 cycles bcd_out=12'h255, seg_out={0100100,0010010,0010010}.
- count_in=7 -> bcd_out=12'h007, seg_out={7F,7F,1111000}; count_in=100 -> 12'h100 with tens shown as 1000000, not blanked.
- count_in=100, then 42 two cycles after capture -> first done with 12'h100, second done with 12'h042 exactly 10 cycles later; exactly two done pulses.
- Assert r during CONV (iter=4) -> outputs return to reset values immediately; after release, one conversion of held count_in and done 9 edges after the first post-reset edge.
